// File: rtl/register_file_wb.sv
// register_file_wb: NREG x DATA_W write-back register file with two
// registered read ports, same-cycle write bypass, a read-freeze (hold)
// input and a free-running count of retired writes.
//
// There is no valid/ready handshake on this block: a write is taken on
// every rising edge where we_r=1, and a read address pair is taken on
// every rising edge where hold=0. The results appear on rd_data/s0 after
// that edge. Reset (rst=1) overrides both the write and the hold.
module register_file_wb #(
   parameter int DATA_W = 16,
   parameter int NREG   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_r,
   input  logic [3:0]        rdest_rr,
   input  logic [DATA_W-1:0] s2,
   input  logic [3:0]        rsrc_a,
   input  logic [3:0]        rsrc_b,
   input  logic              hold,
   output logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] s0,
   output logic [15:0]       wb_count
);

   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] arr_a;
   logic [DATA_W-1:0] arr_b;
   logic [DATA_W-1:0] next_a;
   logic [DATA_W-1:0] next_b;

   // Storage array: every entry (r0 included) is writable; reset clears all.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we_r) begin
         for (int i = 0; i < NREG; i++) begin
            if (rdest_rr == 4'(i)) begin
               regs[i] <= s2;
            end
         end
      end
   end

   // Array read muxes; addresses beyond NREG read as zero.
   always_comb begin
      arr_a = '0;
      arr_b = '0;
      for (int i = 0; i < NREG; i++) begin
         if (rsrc_a == 4'(i)) begin
            arr_a = regs[i];
         end
         if (rsrc_b == 4'(i)) begin
            arr_b = regs[i];
         end
      end
   end

   // Bypass: a write to the address being read wins over the stale entry,
   // independently on each port.
   always_comb begin
      next_a = arr_a;
      next_b = arr_b;
      if (we_r && (rdest_rr == rsrc_a)) begin
         next_a = s2;
      end
      if (we_r && (rdest_rr == rsrc_b)) begin
         next_b = s2;
      end
   end

   // Read-output registers: frozen while hold=1, reloaded on release.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
         s0      <= '0;
      end else if (!hold) begin
         rd_data <= next_a;
         s0      <= next_b;
      end
   end

   // Retired-write counter; wraps naturally at 16 bits, unaffected by hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_count <= '0;
      end else if (we_r) begin
         wb_count <= wb_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_register_file_wb.sv
// Testbench for register_file_wb: directed scenarios plus randomized
// traffic, checked through an expected-value queue against a
// behavioural model of the register file.
module tb_register_file_wb;

   localparam int W = 16;

   logic          clk;
   logic          rst;
   logic          we_r;
   logic [3:0]    rdest_rr;
   logic [W-1:0]  s2;
   logic [3:0]    rsrc_a;
   logic [3:0]    rsrc_b;
   logic          hold;
   logic [W-1:0]  rd_data;
   logic [W-1:0]  s0;
   logic [15:0]   wb_count;

   register_file_wb #(.DATA_W(W), .NREG(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .we_r     (we_r),
      .rdest_rr (rdest_rr),
      .s2       (s2),
      .rsrc_a   (rsrc_a),
      .rsrc_b   (rsrc_b),
      .hold     (hold),
      .rd_data  (rd_data),
      .s0       (s0),
      .wb_count (wb_count)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model state
   logic [W-1:0]  m_mem [16];
   logic [W-1:0]  m_a;
   logic [W-1:0]  m_b;
   logic [15:0]   m_cnt;

   // scoreboard
   logic [3*W-1:0] exp_q[$];
   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [W-1:0] got,
                        input logic [W-1:0] want);
      total_cnt++;
      if (got === want) pass_cnt++;
      else $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
   endtask

   // monitor: each edge presents one result; compare it with the oldest expectation
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [3*W-1:0] e;
         e = exp_q.pop_front();
         check("rd_data",  rd_data,  e[3*W-1:2*W]);
         check("s0",       s0,       e[2*W-1:W]);
         check("wb_count", wb_count, e[W-1:0]);
      end
   end

   // driver: present one cycle of inputs, push the expected response, advance model
   task automatic cycle(input logic r, input logic we, input logic [3:0] wa,
                        input logic [W-1:0] wd, input logic [3:0] ra,
                        input logic [3:0] rb, input logic h);
      @(negedge clk);
      rst = r; we_r = we; rdest_rr = wa; s2 = wd;
      rsrc_a = ra; rsrc_b = rb; hold = h;
      if (r) begin
         foreach (m_mem[i]) m_mem[i] = '0;
         m_a = '0; m_b = '0; m_cnt = '0;
      end else begin
         if (!h) begin
            m_a = (we && wa == ra) ? wd : m_mem[ra];
            m_b = (we && wa == rb) ? wd : m_mem[rb];
         end
         if (we) begin
            m_mem[wa] = wd;
            m_cnt = m_cnt + 16'd1;
         end
      end
      exp_q.push_back({m_a, m_b, m_cnt});
   endtask

   task automatic idle_read(input logic [3:0] ra, input logic [3:0] rb);
      cycle(1'b0, 1'b0, 4'd0, '0, ra, rb, 1'b0);
   endtask

   initial begin
      rst = 1'b1; we_r = 1'b0; rdest_rr = '0; s2 = '0;
      rsrc_a = '0; rsrc_b = '0; hold = 1'b0;
      foreach (m_mem[i]) m_mem[i] = '0;
      m_a = '0; m_b = '0; m_cnt = '0;

      // reset, then read every address
      cycle(1'b1, 1'b0, 4'd0, '0, 4'd0, 4'd0, 1'b0);
      cycle(1'b1, 1'b1, 4'd9, 16'h7777, 4'd9, 4'd9, 1'b1);
      for (int a = 0; a < 16; a++) idle_read(4'(a), 4'(15 - a));

      // write r5 then read it back
      cycle(1'b0, 1'b1, 4'd5, 16'h1234, 4'd0, 4'd0, 1'b0);
      idle_read(4'd5, 4'd0);

      // same-cycle bypass on both ports
      cycle(1'b0, 1'b1, 4'd3, 16'hBEEF, 4'd3, 4'd3, 1'b0);
      idle_read(4'd3, 4'd5);

      // hold freezes outputs; write during hold is visible after release
      cycle(1'b0, 1'b1, 4'd1, 16'h1111, 4'd1, 4'd1, 1'b0);
      cycle(1'b0, 1'b1, 4'd1, 16'h2222, 4'd1, 4'd1, 1'b1);
      cycle(1'b0, 1'b0, 4'd0, '0, 4'd1, 4'd1, 1'b1);
      cycle(1'b0, 1'b0, 4'd0, '0, 4'd1, 4'd1, 1'b0);

      // back-to-back writes to the same address: last one sticks, all counted
      cycle(1'b0, 1'b1, 4'd0, 16'h0A0A, 4'd2, 4'd2, 1'b0);
      cycle(1'b0, 1'b1, 4'd0, 16'h0B0B, 4'd0, 4'd2, 1'b0);
      cycle(1'b0, 1'b1, 4'd0, 16'h0C0C, 4'd2, 4'd0, 1'b0);
      idle_read(4'd0, 4'd0);

      // write discarded under reset
      cycle(1'b0, 1'b1, 4'd7, 16'hAAAA, 4'd0, 4'd0, 1'b0);
      idle_read(4'd7, 4'd7);
      cycle(1'b1, 1'b1, 4'd7, 16'h5555, 4'd7, 4'd7, 1'b0);
      idle_read(4'd7, 4'd7);

      // randomized traffic, including occasional hold and reset
      for (int n = 0; n < 600; n++) begin
         cycle(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 16'($urandom),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0));
      end

      // counter wrap: 65535 writes to reach 0xFFFF, then one more
      cycle(1'b1, 1'b0, 4'd0, '0, 4'd0, 4'd0, 1'b0);
      for (int n = 0; n < 65535; n++) begin
         cycle(1'b0, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      end
      cycle(1'b0, 1'b1, 4'd4, 16'hFACE, 4'd4, 4'd6, 1'b0);
      idle_read(4'd4, 4'd4);

      // drain the scoreboard
      repeat (3) @(negedge clk);
      total_cnt++;
      if (exp_q.size() == 0) pass_cnt++;
      else $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
